// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding, occupancy
// width and the state-to-occupancy decode.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Number of entries held in each state; the unused encoding reports empty
  function automatic logic [OCC_W-1:0] stateOccupancy(input state_e s);
    case (s)
      ST_HALF: stateOccupancy = 2'd1;
      ST_FULL: stateOccupancy = 2'd2;
      default: stateOccupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One stored pipeline entry (payload + control). Clearing kills the entry by
// zeroing its control field; the payload is only wiped when CLEAR_DATA is set.
module pipe_entry_reg #(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 10,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Entry storage: reset clears everything, clear beats load so a flush always wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (clear_i) begin
      ctrl_q <= '0;
      if (CLEAR_DATA) data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register with valid/ready handshake. The storage
// variant keeps a main entry (presented downstream) and a skid entry so that
// in_ready comes straight from flops while still sustaining one entry per
// cycle. The BYPASS variant is pure wiring.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 10,
  parameter bit GATE_CTRL  = 1'b1,
  parameter bit CLEAR_DATA = 1'b0,
  parameter bit BYPASS     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  generate
    if (BYPASS) begin : gBypass

      // Clock and reset are not needed when the stage is only wires
      logic bypassUnused;
      assign bypassUnused = ^{clk, rst};

      assign out_valid = in_valid & ~flush;
      assign in_ready  = out_ready;
      assign out_data  = in_data;
      assign out_ctrl  = (GATE_CTRL && !out_valid) ? '0 : in_ctrl;
      assign occupancy = '0;

    end else begin : gStore

      state_e            state_q;
      state_e            state_d;
      logic              inXfer;
      logic              outXfer;
      logic              mLoad;
      logic              sLoad;
      logic              mFromSkid;
      logic              validQ;
      logic              readyQ;
      logic [DATA_W-1:0] mData;
      logic [CTRL_W-1:0] mCtrl;
      logic [DATA_W-1:0] sData;
      logic [CTRL_W-1:0] sCtrl;
      logic [DATA_W-1:0] mDataIn;
      logic [CTRL_W-1:0] mCtrlIn;

      // Handshake flags decode only the state flops, so in_ready has no path from out_ready
      assign validQ  = (state_q == ST_HALF) || (state_q == ST_FULL);
      assign readyQ  = (state_q == ST_EMPTY) || (state_q == ST_HALF);
      assign inXfer  = in_valid & readyQ;
      assign outXfer = validQ & out_ready;

      // Next-state and entry-load decisions; flush overrides everything and drops any incoming entry
      always_comb begin
        state_d   = state_q;
        mLoad     = 1'b0;
        sLoad     = 1'b0;
        mFromSkid = 1'b0;
        if (flush) begin
          state_d = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (inXfer) begin
                state_d = ST_HALF;
                mLoad   = 1'b1;
              end
            end
            ST_HALF: begin
              if (inXfer && outXfer) begin
                mLoad = 1'b1;
              end else if (inXfer) begin
                state_d = ST_FULL;
                sLoad   = 1'b1;
              end else if (outXfer) begin
                state_d = ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (outXfer) begin
                state_d   = ST_HALF;
                mLoad     = 1'b1;
                mFromSkid = 1'b1;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      // State register; an illegal encoding falls back to empty on the next edge
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_EMPTY;
        else      state_q <= state_d;
      end

      assign mDataIn = mFromSkid ? sData : in_data;
      assign mCtrlIn = mFromSkid ? sCtrl : in_ctrl;

      pipe_entry_reg #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CLEAR_DATA(CLEAR_DATA)
      ) uMain (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (mLoad),
        .clear_i(flush),
        .data_i (mDataIn),
        .ctrl_i (mCtrlIn),
        .data_o (mData),
        .ctrl_o (mCtrl)
      );

      pipe_entry_reg #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CLEAR_DATA(CLEAR_DATA)
      ) uSkid (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (sLoad),
        .clear_i(flush),
        .data_i (in_data),
        .ctrl_i (in_ctrl),
        .data_o (sData),
        .ctrl_o (sCtrl)
      );

      assign out_valid = validQ;
      assign in_ready  = readyQ;
      assign out_data  = mData;
      assign out_ctrl  = (GATE_CTRL && !validQ) ? '0 : mCtrl;
      assign occupancy = stateOccupancy(state_q);

    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a random
// valid/ready/flush run tracked by an in-order scoreboard, and a separate
// BYPASS instance for the wire-through variant.
module tb_pipe_skid_stage;

  localparam int DW = 96;
  localparam int CW = 10;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [DW-1:0] inData = '0;
  logic [CW-1:0] inCtrl = '0;
  logic          outValid;
  logic          outReady = 1'b0;
  logic [DW-1:0] outData;
  logic [CW-1:0] outCtrl;
  logic [1:0]    occupancy;

  logic          bpFlush = 1'b0;
  logic          bpInValid = 1'b0;
  logic          bpInReady;
  logic [DW-1:0] bpInData = '0;
  logic [CW-1:0] bpInCtrl = '0;
  logic          bpOutValid;
  logic          bpOutReady = 1'b0;
  logic [DW-1:0] bpOutData;
  logic [CW-1:0] bpOutCtrl;
  logic [1:0]    bpOccupancy;

  int     vectorsApplied = 0;
  int     miscompares = 0;
  bit     sbEnable = 1'b0;
  entry_t sb[$];
  bit     stallPrev = 1'b0;
  entry_t prevOut;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .DATA_W(DW), .CTRL_W(CW), .GATE_CTRL(1'b1), .CLEAR_DATA(1'b0), .BYPASS(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_ctrl(inCtrl),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_ctrl(outCtrl),
    .occupancy(occupancy)
  );

  pipe_skid_stage #(
    .DATA_W(DW), .CTRL_W(CW), .GATE_CTRL(1'b1), .CLEAR_DATA(1'b0), .BYPASS(1'b1)
  ) dutBp (
    .clk(clk), .rst(rst), .flush(bpFlush),
    .in_valid(bpInValid), .in_ready(bpInReady), .in_data(bpInData), .in_ctrl(bpInCtrl),
    .out_valid(bpOutValid), .out_ready(bpOutReady), .out_data(bpOutData), .out_ctrl(bpOutCtrl),
    .occupancy(bpOccupancy)
  );

  // Scoreboard monitor: mid-cycle it checks occupancy against the queue depth, control gating,
  // stability under stall and output order, then records what the DUT accepts on the coming edge
  always @(negedge clk) begin
    if (sbEnable && rst) begin
      vectorsApplied++;
      if (occupancy !== 2'(sb.size())) begin
        miscompares++;
        $display("[TB] FAIL occupancy_model: got %0d, expected %0d", occupancy, sb.size());
      end
      if (!outValid) begin
        vectorsApplied++;
        if (outCtrl !== '0) begin
          miscompares++;
          $display("[TB] FAIL ctrl_gating: got %h, expected 0", outCtrl);
        end
      end
      if (stallPrev) begin
        vectorsApplied++;
        if (!outValid || outData !== prevOut.data || outCtrl !== prevOut.ctrl) begin
          miscompares++;
          $display("[TB] FAIL stall_stability: got v=%b %h/%h, expected v=1 %h/%h",
                   outValid, outData, outCtrl, prevOut.data, prevOut.ctrl);
        end
      end
      if (outValid && outReady) begin
        vectorsApplied++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_output: got %h/%h, expected nothing", outData, outCtrl);
        end else begin
          entry_t exp;
          exp = sb.pop_front();
          if (outData !== exp.data || outCtrl !== exp.ctrl) begin
            miscompares++;
            $display("[TB] FAIL sb_order: got %h/%h, expected %h/%h",
                     outData, outCtrl, exp.data, exp.ctrl);
          end
        end
      end
      if (flush) sb.delete();
      else if (inValid && inReady) sb.push_back('{data: inData, ctrl: inCtrl});
      stallPrev    = outValid && !outReady && !flush;
      prevOut.data = outData;
      prevOut.ctrl = outCtrl;
    end else begin
      stallPrev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    inValid  = 1'b1;
    inData   = 96'h99;
    inCtrl   = 10'h3FF;
    outReady = 1'b1;
    repeat (3) tick();
    vectorsApplied++;
    if (outValid !== 1'b0 || outCtrl !== '0 || occupancy !== 2'd0 || outData !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got v=%b c=%h o=%0d d=%h, expected 0/0/0/0",
               outValid, outCtrl, occupancy, outData);
    end
    rst = 1'b1;
    sbEnable = 1'b1;
    #1;
    vectorsApplied++;
    if (inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", inReady);
    end
    tick();
    vectorsApplied++;
    if (outValid !== 1'b1 || outData !== 96'h99) begin
      miscompares++;
      $display("[TB] FAIL first_accept: got v=%b d=%h, expected v=1 d=99", outValid, outData);
    end
    inValid = 1'b0;
    tick();
    vectorsApplied++;
    if (occupancy !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_drain: got %0d, expected 0", occupancy);
    end
  endtask

  task automatic test_stream();
    outReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      inValid = 1'b1;
      inData  = DW'(i);
      inCtrl  = CW'(i);
      #1;
      vectorsApplied++;
      if (inReady !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stream_in_ready: got %b, expected 1 (item %0d)", inReady, i);
      end
      tick();
      vectorsApplied++;
      if (occupancy !== 2'd1 || outValid !== 1'b1 || outData !== DW'(i)) begin
        miscompares++;
        $display("[TB] FAIL stream_latency: got o=%0d v=%b d=%h, expected o=1 v=1 d=%h",
                 occupancy, outValid, outData, DW'(i));
      end
    end
    inValid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    outReady = 1'b0;
    inValid  = 1'b1;
    inData   = 96'hAA;
    inCtrl   = 10'h0A;
    tick();
    inData   = 96'hBB;
    inCtrl   = 10'h0B;
    tick();
    inValid  = 1'b0;
    #1;
    vectorsApplied++;
    if (occupancy !== 2'd2 || inReady !== 1'b0 || outData !== 96'hAA) begin
      miscompares++;
      $display("[TB] FAIL stall_full: got o=%0d r=%b d=%h, expected o=2 r=0 d=AA",
               occupancy, inReady, outData);
    end
    tick();
    vectorsApplied++;
    if (outData !== 96'hAA || inReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_hold: got r=%b d=%h, expected r=0 d=AA", inReady, outData);
    end
    outReady = 1'b1;
    tick();
    vectorsApplied++;
    if (inReady !== 1'b1 || outData !== 96'hBB || occupancy !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got r=%b d=%h o=%0d, expected r=1 d=BB o=1",
               inReady, outData, occupancy);
    end
    tick();
    vectorsApplied++;
    if (outValid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL stall_drain: got v=%b o=%0d, expected v=0 o=0", outValid, occupancy);
    end
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    inValid  = 1'b1;
    inData   = 96'h11;
    inCtrl   = 10'h3FF;
    tick();
    inData   = 96'h22;
    tick();
    vectorsApplied++;
    if (outCtrl !== 10'h3FF || occupancy !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL flush_pre: got c=%h o=%0d, expected c=3FF o=2", outCtrl, occupancy);
    end
    inData = 96'hCC;
    flush  = 1'b1;
    tick();
    flush   = 1'b0;
    inValid = 1'b0;
    vectorsApplied++;
    if (outValid !== 1'b0 || outCtrl !== '0 || occupancy !== 2'd0 || inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_kill: got v=%b c=%h o=%0d r=%b, expected 0/0/0/1",
               outValid, outCtrl, occupancy, inReady);
    end
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectorsApplied++;
      if (outValid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flush_no_cc: got v=%b d=%h, expected v=0", outValid, outData);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      outReady = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 63) == 0);
      inData   = {$urandom, $urandom, $urandom};
      inCtrl   = CW'($urandom);
      tick();
    end
    inValid  = 1'b0;
    flush    = 1'b0;
    outReady = 1'b1;
    repeat (4) tick();
    vectorsApplied++;
    if (sb.size() != 0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL random_drain: got left=%0d o=%0d, expected 0/0", sb.size(), occupancy);
    end
  endtask

  task automatic test_bypass();
    bpInValid  = 1'b1;
    bpInData   = 96'h55;
    bpInCtrl   = 10'h155;
    bpOutReady = 1'b1;
    bpFlush    = 1'b0;
    #1;
    vectorsApplied++;
    if (bpOutValid !== 1'b1 || bpOutData !== 96'h55 || bpOutCtrl !== 10'h155 ||
        bpInReady !== 1'b1 || bpOccupancy !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL bypass_pass: got v=%b d=%h c=%h r=%b o=%0d, expected 1/55/155/1/0",
               bpOutValid, bpOutData, bpOutCtrl, bpInReady, bpOccupancy);
    end
    bpOutReady = 1'b0;
    #1;
    vectorsApplied++;
    if (bpInReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bypass_ready: got %b, expected 0", bpInReady);
    end
    bpFlush = 1'b1;
    #1;
    vectorsApplied++;
    if (bpOutValid !== 1'b0 || bpOutCtrl !== '0) begin
      miscompares++;
      $display("[TB] FAIL bypass_flush: got v=%b c=%h, expected v=0 c=0", bpOutValid, bpOutCtrl);
    end
    bpFlush = 1'b0;
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_random();
    test_bypass();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
